// File: rtl/spi_word_serializer_pkg.sv
// -----------------------------------------------------------------------------
// spi_word_serializer_pkg
// Shared definitions for the word <-> byte SPI serializer: default widths,
// the TX FSM state encoding and a helper that sizes the byte counter.
// No ports (package).
// -----------------------------------------------------------------------------
package spi_word_serializer_pkg;

  localparam int DATA_WIDTH_DEFAULT     = 32;
  localparam int SPI_DATA_WIDTH_DEFAULT = 8;

  typedef enum logic {
    ST_IDLE  = 1'b0,
    ST_SHIFT = 1'b1
  } state_t;

  // Counter width for 0..bytes-1; a one-byte word still needs a 1-bit counter.
  function automatic int cnt_width(input int bytes);
    return (bytes > 1) ? $clog2(bytes) : 1;
  endfunction

endpackage

// File: rtl/spi_word_serializer_if.sv
// -----------------------------------------------------------------------------
// spi_word_serializer_if
// Bundles the buffer-side word handshake and the SPI-core-side byte signals.
//   slave  modport : the serializer (drives word_ack, rx_word, rx_word_wr,
//                    spi_data_send, frame_error)
//   master modport : the surroundings (buffers, SPI core, CSR for clr_err)
// -----------------------------------------------------------------------------
interface spi_word_serializer_if
  import spi_word_serializer_pkg::*;
#(
  parameter int DATA_WIDTH     = DATA_WIDTH_DEFAULT,
  parameter int SPI_DATA_WIDTH = SPI_DATA_WIDTH_DEFAULT
);

  logic                      word_valid;
  logic [DATA_WIDTH-1:0]     word_in;
  logic                      word_ack;
  logic [DATA_WIDTH-1:0]     rx_word;
  logic                      rx_word_wr;
  logic [SPI_DATA_WIDTH-1:0] spi_data_send;
  logic [SPI_DATA_WIDTH-1:0] spi_data_receive;
  logic                      spi_ready;
  logic                      spi_select;
  logic                      frame_error;
  logic                      clr_err;

  modport slave (
    input  word_valid, word_in, spi_data_receive, spi_ready, spi_select, clr_err,
    output word_ack, rx_word, rx_word_wr, spi_data_send, frame_error
  );

  modport master (
    output word_valid, word_in, spi_data_receive, spi_ready, spi_select, clr_err,
    input  word_ack, rx_word, rx_word_wr, spi_data_send, frame_error
  );

endinterface

// File: rtl/spi_word_serializer_shifter.sv
// -----------------------------------------------------------------------------
// spi_byte_shifter
// Generic shift register with parallel load that shifts left by STEP bits,
// inserting shift_in at the bottom.
//   clk, rst (sync, active-low)
//   clr       : clear to zero (highest priority)
//   load      : load load_data
//   shift     : shift left by STEP, shift_in enters the LSBs
//   data      : current register contents
// -----------------------------------------------------------------------------
module spi_byte_shifter #(
  parameter int WIDTH = 32,
  parameter int STEP  = 8
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             clr,
  input  logic             load,
  input  logic [WIDTH-1:0] load_data,
  input  logic             shift,
  input  logic [STEP-1:0]  shift_in,
  output logic [WIDTH-1:0] data
);

  logic [WIDTH-1:0]      data_reg;
  // Concatenate then truncate so WIDTH == STEP needs no special slice.
  logic [WIDTH+STEP-1:0] ext;
  logic [STEP-1:0]       unused_top;

  assign ext        = {data_reg, shift_in};
  assign unused_top = ext[WIDTH+STEP-1 -: STEP];
  assign data       = data_reg;

  always_ff @(posedge clk) begin
    if (!rst) begin
      data_reg <= '0;
    end else if (clr) begin
      data_reg <= '0;
    end else if (load) begin
      data_reg <= load_data;
    end else if (shift) begin
      data_reg <= ext[WIDTH-1:0];
    end
  end

endmodule

// File: rtl/spi_word_serializer.sv
// -----------------------------------------------------------------------------
// spi_word_serializer
// Full-duplex bridge between word-wide transfer buffers and a byte-wide SPI
// slave core. TX words go out MSB byte first; RX bytes are packed MSB first
// into words. Every completed byte exchange advances both directions.
//   clk  : system clock
//   rst  : synchronous, active-low reset
//   bus  : spi_word_serializer_if.slave (word handshake, rx word strobe,
//          SPI byte signals, chip select, sticky frame_error / clr_err)
// -----------------------------------------------------------------------------
module spi_word_serializer
  import spi_word_serializer_pkg::*;
#(
  parameter int DATA_WIDTH     = DATA_WIDTH_DEFAULT,
  parameter int SPI_DATA_WIDTH = SPI_DATA_WIDTH_DEFAULT
) (
  input  logic clk,
  input  logic rst,
  spi_word_serializer_if.slave bus
);

  localparam int BYTES     = DATA_WIDTH / SPI_DATA_WIDTH;
  localparam int CNT_WIDTH = cnt_width(BYTES);
  localparam logic [CNT_WIDTH-1:0] LAST_BYTE = CNT_WIDTH'(BYTES - 1);

  state_t                    state_reg, state_next;
  logic [CNT_WIDTH-1:0]      byte_cnt_reg;
  logic                      select_reg;
  logic [SPI_DATA_WIDTH-1:0] send_reg, send_next;
  logic [DATA_WIDTH-1:0]     rx_word_reg;
  logic                      rx_word_wr_reg;
  logic                      frame_error_reg;

  logic accept, select_fall, last_byte;
  logic ack_raw, word_ack, tx_shift_en;

  logic [DATA_WIDTH-1:0]                tx_data, rx_data;
  logic [SPI_DATA_WIDTH-1:0]            tx_next_top;
  logic [DATA_WIDTH+SPI_DATA_WIDTH-1:0] rx_ext;
  logic                                 unused_bits;

  assign accept      = bus.spi_ready && bus.spi_select;
  assign select_fall = select_reg && !bus.spi_select;
  assign last_byte   = (byte_cnt_reg == LAST_BYTE);

  // Byte that becomes the top of tx_shift after one shift.
  generate
    if (BYTES > 1) begin : g_multi
      assign tx_next_top = tx_data[DATA_WIDTH-SPI_DATA_WIDTH-1 -: SPI_DATA_WIDTH];
    end else begin : g_single
      assign tx_next_top = '0;
    end
  endgenerate

  // Word completed by the byte arriving now.
  assign rx_ext      = {rx_data, bus.spi_data_receive};
  assign unused_bits = ^{tx_data, rx_ext[DATA_WIDTH+SPI_DATA_WIDTH-1 -: SPI_DATA_WIDTH]};

  // TX FSM next state / outputs. A select drop overrides any byte event.
  always_comb begin
    state_next  = state_reg;
    send_next   = send_reg;
    ack_raw     = 1'b0;
    tx_shift_en = 1'b0;
    if (select_fall) begin
      state_next = ST_IDLE;
      send_next  = '0;
    end else begin
      case (state_reg)
        ST_IDLE: begin
          send_next = '0;
          // Only start on a word boundary and not while a byte completes.
          if (bus.word_valid && byte_cnt_reg == '0 && !bus.spi_ready) begin
            ack_raw    = 1'b1;
            send_next  = bus.word_in[DATA_WIDTH-1 -: SPI_DATA_WIDTH];
            state_next = ST_SHIFT;
          end
        end
        ST_SHIFT: begin
          if (accept) begin
            if (last_byte) begin
              if (bus.word_valid) begin
                // Back-to-back word: load now so no filler byte appears.
                ack_raw   = 1'b1;
                send_next = bus.word_in[DATA_WIDTH-1 -: SPI_DATA_WIDTH];
              end else begin
                send_next  = '0;
                state_next = ST_IDLE;
              end
            end else begin
              tx_shift_en = 1'b1;
              send_next   = tx_next_top;
            end
          end
        end
        default: begin
          state_next = ST_IDLE;
          send_next  = '0;
        end
      endcase
    end
  end

  assign word_ack = ack_raw && rst;

  always_ff @(posedge clk) begin
    if (!rst) begin
      state_reg       <= ST_IDLE;
      byte_cnt_reg    <= '0;
      select_reg      <= 1'b0;
      send_reg        <= '0;
      rx_word_reg     <= '0;
      rx_word_wr_reg  <= 1'b0;
      frame_error_reg <= 1'b0;
    end else begin
      state_reg  <= state_next;
      send_reg   <= send_next;
      select_reg <= bus.spi_select;

      if (select_fall) begin
        byte_cnt_reg <= '0;
      end else if (accept) begin
        byte_cnt_reg <= last_byte ? '0 : byte_cnt_reg + 1'b1;
      end

      rx_word_wr_reg <= accept && last_byte;
      if (accept && last_byte) begin
        rx_word_reg <= rx_ext[DATA_WIDTH-1:0];
      end

      // Set has priority over clear.
      if (select_fall && byte_cnt_reg != '0) begin
        frame_error_reg <= 1'b1;
      end else if (bus.clr_err) begin
        frame_error_reg <= 1'b0;
      end
    end
  end

  spi_byte_shifter #(
    .WIDTH (DATA_WIDTH),
    .STEP  (SPI_DATA_WIDTH)
  ) u_tx_shift (
    .clk       (clk),
    .rst       (rst),
    .clr       (select_fall),
    .load      (word_ack),
    .load_data (bus.word_in),
    .shift     (tx_shift_en),
    .shift_in  ({SPI_DATA_WIDTH{1'b0}}),
    .data      (tx_data)
  );

  spi_byte_shifter #(
    .WIDTH (DATA_WIDTH),
    .STEP  (SPI_DATA_WIDTH)
  ) u_rx_shift (
    .clk       (clk),
    .rst       (rst),
    .clr       (select_fall),
    .load      (1'b0),
    .load_data ({DATA_WIDTH{1'b0}}),
    .shift     (accept),
    .shift_in  (bus.spi_data_receive),
    .data      (rx_data)
  );

  assign bus.word_ack      = word_ack;
  assign bus.rx_word       = rx_word_reg;
  assign bus.rx_word_wr    = rx_word_wr_reg;
  assign bus.spi_data_send = send_reg;
  assign bus.frame_error   = frame_error_reg;

endmodule

// File: tb/tb_spi_word_serializer.sv
// -----------------------------------------------------------------------------
// tb_spi_word_serializer
// Directed bench for spi_word_serializer (32-bit words, 8-bit bytes).
// Upstream buffer is a queue of words advanced on word_valid && word_ack;
// expected TX bytes and RX words are queued as stimulus is written and
// popped when the DUT exchanges a byte or strobes rx_word_wr.
// -----------------------------------------------------------------------------
module tb_spi_word_serializer;

  logic clk = 1'b0;
  logic rst;
  always #5 clk = ~clk;

  spi_word_serializer_if bus ();

  spi_word_serializer dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  int checks   = 0;
  int failures = 0;
  int acks     = 0;

  logic [31:0] up_q[$];
  logic [7:0]  exp_tx[$];
  logic [31:0] exp_rx[$];

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] expv);
    checks++;
    assert (obs === expv) else begin
      failures++;
      $error("FAIL %s: observed=%h expected=%h", tag, obs, expv);
    end
  endtask

  task automatic drive_upstream();
    bus.word_valid = (up_q.size() != 0);
    bus.word_in    = (up_q.size() != 0) ? up_q[0] : 32'h0;
  endtask

  // One clock: sample outputs on the falling edge, advance inputs after the rising edge.
  task automatic tick();
    logic took;
    logic [7:0]  eb;
    logic [31:0] ew;
    @(negedge clk);
    took = bus.word_valid && bus.word_ack;
    if (bus.spi_ready && bus.spi_select && rst) begin
      $display("byte: send=%h receive=%h", bus.spi_data_send, bus.spi_data_receive);
      checks++;
      assert (exp_tx.size() != 0) else begin
        failures++;
        $error("FAIL tx_unexpected: observed byte=%h expected none", bus.spi_data_send);
      end
      if (exp_tx.size() != 0) begin
        eb = exp_tx.pop_front();
        chk("tx_byte", {24'h0, bus.spi_data_send}, {24'h0, eb});
      end
    end
    if (bus.rx_word_wr) begin
      $display("rx word: %h", bus.rx_word);
      checks++;
      assert (exp_rx.size() != 0) else begin
        failures++;
        $error("FAIL rx_unexpected: observed word=%h expected none", bus.rx_word);
      end
      if (exp_rx.size() != 0) begin
        ew = exp_rx.pop_front();
        chk("rx_word", bus.rx_word, ew);
      end
    end
    if (took) begin
      acks++;
      $display("word ack: %h", bus.word_in);
    end
    @(posedge clk);
    #1;
    if (took) begin
      void'(up_q.pop_front());
      drive_upstream();
    end
  endtask

  task automatic ready_byte(input logic [7:0] rx);
    bus.spi_data_receive = rx;
    bus.spi_ready        = 1'b1;
    tick();
    bus.spi_ready        = 1'b0;
    tick();
    tick();
  endtask

  task automatic push_tx_word(input logic [31:0] w);
    exp_tx.push_back(w[31:24]);
    exp_tx.push_back(w[23:16]);
    exp_tx.push_back(w[15:8]);
    exp_tx.push_back(w[7:0]);
  endtask

  task automatic xfer_word(input logic [31:0] tx_w, input logic [31:0] rx_w);
    push_tx_word(tx_w);
    exp_rx.push_back(rx_w);
    ready_byte(rx_w[31:24]);
    ready_byte(rx_w[23:16]);
    ready_byte(rx_w[15:8]);
    ready_byte(rx_w[7:0]);
  endtask

  task automatic end_test(input string name);
    tick();
    tick();
    chk({name, "_tx_left"}, 32'(exp_tx.size()), 32'd0);
    chk({name, "_rx_left"}, 32'(exp_rx.size()), 32'd0);
  endtask

  initial begin
    rst                  = 1'b0;
    bus.spi_select       = 1'b0;
    bus.spi_ready        = 1'b0;
    bus.spi_data_receive = 8'h00;
    bus.clr_err          = 1'b0;
    drive_upstream();
    tick(); tick(); tick();

    // Reset state
    chk("rst_send", {24'h0, bus.spi_data_send}, 32'h0);
    chk("rst_rx_word", bus.rx_word, 32'h0);
    chk("rst_rx_wr", {31'h0, bus.rx_word_wr}, 32'h0);
    chk("rst_frame_err", {31'h0, bus.frame_error}, 32'h0);
    chk("rst_ack", {31'h0, bus.word_ack}, 32'h0);

    rst = 1'b1;
    tick();
    bus.spi_select = 1'b1;
    tick(); tick();

    // 1: single word, full duplex
    acks = 0;
    up_q.push_back(32'hA1B2C3D4);
    drive_upstream();
    tick(); tick();
    chk("t1_ack_load", 32'(acks), 32'd1);
    chk("t1_first_byte", {24'h0, bus.spi_data_send}, 32'hA1);
    xfer_word(32'hA1B2C3D4, 32'h11223344);
    end_test("t1");
    chk("t1_acks", 32'(acks), 32'd1);
    chk("t1_send_idle", {24'h0, bus.spi_data_send}, 32'h0);
    chk("t1_rx_hold", bus.rx_word, 32'h11223344);

    // 2: two queued words, no gap byte between them
    acks = 0;
    up_q.push_back(32'hDEADBEEF);
    up_q.push_back(32'h01020304);
    drive_upstream();
    tick(); tick();
    xfer_word(32'hDEADBEEF, 32'h55667788);
    chk("t2_ack_boundary", 32'(acks), 32'd2);
    xfer_word(32'h01020304, 32'h99AABBCC);
    end_test("t2");
    chk("t2_acks", 32'(acks), 32'd2);

    // 3: nothing to send, receive still assembles
    acks = 0;
    xfer_word(32'h00000000, 32'hCAFEBABE);
    end_test("t3");
    chk("t3_acks", 32'(acks), 32'd0);
    chk("t3_rx_hold", bus.rx_word, 32'hCAFEBABE);

    // 4: select drop mid-word
    acks = 0;
    up_q.push_back(32'hA1B2C3D4);
    drive_upstream();
    tick(); tick();
    exp_tx.push_back(8'hA1);
    exp_tx.push_back(8'hB2);
    ready_byte(8'h55);
    ready_byte(8'h66);
    bus.spi_select = 1'b0;
    tick();
    chk("t4_frame_err_set", {31'h0, bus.frame_error}, 32'h1);
    chk("t4_send_zero", {24'h0, bus.spi_data_send}, 32'h0);
    chk("t4_acks", 32'(acks), 32'd1);
    // Byte completion while deselected must be ignored.
    bus.spi_data_receive = 8'h77;
    bus.spi_ready        = 1'b1;
    tick();
    bus.spi_ready        = 1'b0;
    tick();
    bus.spi_select = 1'b1;
    tick(); tick();
    xfer_word(32'h00000000, 32'h0F1E2D3C);
    end_test("t4");
    chk("t4_frame_err_sticky", {31'h0, bus.frame_error}, 32'h1);
    bus.clr_err = 1'b1;
    tick();
    bus.clr_err = 1'b0;
    chk("t4_frame_err_clr", {31'h0, bus.frame_error}, 32'h0);

    // 5: word arrives mid-word while idle, waits for the boundary
    acks = 0;
    exp_tx.push_back(8'h00);
    ready_byte(8'h10);
    up_q.push_back(32'h0A0B0C0D);
    drive_upstream();
    exp_tx.push_back(8'h00);
    exp_tx.push_back(8'h00);
    ready_byte(8'h20);
    ready_byte(8'h30);
    chk("t5_no_ack_yet", 32'(acks), 32'd0);
    exp_tx.push_back(8'h00);
    exp_rx.push_back(32'h10203040);
    ready_byte(8'h40);
    chk("t5_ack_boundary", 32'(acks), 32'd1);
    xfer_word(32'h0A0B0C0D, 32'h50607080);
    end_test("t5");

    // 6: reset mid-word
    acks = 0;
    up_q.push_back(32'h12345678);
    drive_upstream();
    tick(); tick();
    exp_tx.push_back(8'h12);
    exp_tx.push_back(8'h34);
    ready_byte(8'hAA);
    ready_byte(8'hBB);
    up_q.push_back(32'h9ABCDEF0);
    drive_upstream();
    rst = 1'b0;
    tick();
    chk("t6_send", {24'h0, bus.spi_data_send}, 32'h0);
    chk("t6_rx_word", bus.rx_word, 32'h0);
    chk("t6_rx_wr", {31'h0, bus.rx_word_wr}, 32'h0);
    chk("t6_frame_err", {31'h0, bus.frame_error}, 32'h0);
    chk("t6_ack_in_reset", {31'h0, bus.word_ack}, 32'h0);
    rst = 1'b1;
    tick(); tick();
    chk("t6_acks", 32'(acks), 32'd2);
    xfer_word(32'h9ABCDEF0, 32'h01234567);
    end_test("t6");

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/spi_word_serializer.md
Name: spi_word_serializer

Overview:
Bridges the word-wide SPI transfer buffers to the byte-wide SPI slave core. Pops DATA_WIDTH words from the transmit buffer and presents them MSB-first, one SPI_DATA_WIDTH byte per exchanged byte. Assembles received bytes into words and pushes them to the receive buffer. Full-duplex: every completed SPI byte advances both directions.

Parameters:
DATA_WIDTH, 32, word width on the buffer side; must be an integer multiple of SPI_DATA_WIDTH
SPI_DATA_WIDTH, 8, byte width on the SPI core side
(localparam BYTES = DATA_WIDTH/SPI_DATA_WIDTH; CNT_WIDTH = $clog2(BYTES), minimum 1)

Ports:
clk  in  1  system clock, all logic on rising edge
rst  in  1  reset, synchronous, active-low
word_valid  in  1  tx buffer has a word on word_in
word_in  in  DATA_WIDTH  tx word from buffer
word_ack  out  1  word_in captured this cycle (registered-free, combinational from state)
rx_word  out  DATA_WIDTH  assembled received word
rx_word_wr  out  1  one-cycle write strobe for rx_word
spi_data_send  out  SPI_DATA_WIDTH  byte the SPI core shifts out next
spi_data_receive  in  SPI_DATA_WIDTH  byte just received by the SPI core
spi_ready  in  1  one-cycle pulse: a byte exchange completed
spi_select  in  1  high while the SPI master holds the frame (chip select, synchronised upstream)
frame_error  out  1  sticky: frame aborted mid-word
clr_err  in  1  clears frame_error

Behaviour:
- Reset (rst==0 at posedge): state=ST_IDLE, byte_cnt=0, tx_shift=0, rx_shift=0, spi_data_send=0, rx_word=0, rx_word_wr=0, frame_error=0. word_ack is 0 during reset. Reset mid-frame discards all partial data.
- byte_cnt counts completed bytes within the current word, 0..BYTES-1. It increments on each accepted spi_ready and wraps BYTES-1 -> 0 (word boundary). It counts in every state.
- spi_ready is accepted only when spi_select==1. The SPI core guarantees spi_ready pulses are at least 2 clk apart.
- RX path, on accepted spi_ready:
  - rx_shift <= {rx_shift, spi_data_receive} (MSB first).
  - If byte_cnt==BYTES-1: rx_word <= {rx_shift[DATA_WIDTH-SPI_DATA_WIDTH-1:0], spi_data_receive} and rx_word_wr=1 the next cycle, for exactly one cycle.
- TX FSM:
  - ST_IDLE: spi_data_send=0.
    - If word_valid && byte_cnt==0 && no spi_ready this cycle: word_ack=1, tx_shift<=word_in, spi_data_send<=word_in top byte, go to ST_SHIFT.
    - A word_valid arriving while byte_cnt!=0 waits for the boundary; zeros are sent meanwhile.
  - ST_SHIFT, on accepted spi_ready with byte_cnt<BYTES-1: tx_shift shifts left by SPI_DATA_WIDTH, and spi_data_send <= the new top byte (visible 1 clk after spi_ready).
  - ST_SHIFT, on accepted spi_ready with byte_cnt==BYTES-1 (word done):
    - If word_valid: word_ack=1 in the same cycle and the next word is loaded. No gap byte.
    - Else: spi_data_send<=0 and go to ST_IDLE.
- word_ack is asserted only in the cycle the word is captured; upstream advances on word_valid&&word_ack.
- spi_select falling (1 then 0):
  - byte_cnt<=0, rx_shift<=0, and the state goes to ST_IDLE with spi_data_send=0.
  - A partially sent tx word is dropped; it is not re-sent.
  - If byte_cnt!=0 at that moment, frame_error<=1.
- spi_ready in the same cycle as spi_select==0: the byte is ignored and select handling wins.
- clr_err clears frame_error next cycle. If a set event occurs in the same cycle, set wins.
- No back-pressure on rx: the downstream buffer always accepts rx_word_wr.

Decomposition:
- Shared SPI package/include: SPI_DATA_WIDTH default, state encodings ST_IDLE=0 and ST_SHIFT=1.
- Natural sub-module: spi_byte_shifter, a generic shift register with parallel load and byte-wide shift. Instantiate it twice, once for tx_shift and once for rx_shift.
- FSM and byte counter stay in the top level.

Test Plan:
1. word_in=0xA1B2C3D4 valid, select=1, 4 spi_ready pulses with rx 0x11,0x22,0x33,0x44 -> spi_data_send A1,B2,C3,D4; one word_ack; rx_word=0x11223344 with a single rx_word_wr pulse after the 4th ready.
2. Two words 0xDEADBEEF and 0x01020304 queued, 8 readies -> bytes DE,AD,BE,EF,01,02,03,04 with no 0x00 gap; word_ack at load and at the 4th ready.
3. word_valid=0, 4 readies with rx 0xCA,0xFE,0xBA,0xBE -> spi_data_send stays 0x00; rx_word=0xCAFEBABE.
4. word_valid=0xA1B2C3D4, 2 readies, then select drops -> frame_error=1, no rx_word_wr, byte_cnt=0. Reselect plus 4 readies sends 0x00 (word dropped). clr_err -> frame_error=0.
5. Idle, 1 ready completed, then word_valid raised -> no word_ack until 3 more readies; the word is then sent from its top byte.
6. rst=0 mid-word (after 2 bytes) -> next cycle all outputs 0 and state idle. The following 4 readies assemble a clean rx word.
